// File: rtl/fir_ctrl_pkg.sv
// Shared state type and default sizes for the FIR stream sequencer.
package fir_ctrl_pkg;

    localparam int DEF_INPUT_W  = 16;
    localparam int DEF_OUTPUT_W = 38;
    localparam int DEF_ADDR_W   = 18;
    localparam int DEF_TIMEOUT  = 255;
    localparam int TIMER_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_DONE
    } fir_ctrl_state_t;

endpackage

// File: rtl/fir_timeout_timer.sv
// Counts consecutive cycles spent waiting on the FIR and flags the cycle
// in which the count reaches TimeoutCycles.
module fir_timeout_timer
    import fir_ctrl_pkg::*;
#(
    parameter int TimeoutCycles = DEF_TIMEOUT
) (
    input  logic clkk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W-1:0] w_countNext;

    assign w_countNext = r_count + 1'b1;

    // Flag the enabled cycle whose increment lands on TimeoutCycles, so the
    // waiter sees exactly TimeoutCycles cycles before giving up.
    assign expired = enable && (w_countNext == TIMER_W'(TimeoutCycles));

    always_ff @(posedge clkk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_countNext;
        end
    end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Streams a block of samples from the sample RAM through the FIR core one at
// a time and writes each result to the result RAM, with a response timeout.
module fir_stream_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int InputWidth    = DEF_INPUT_W,
    parameter int OutputWidth   = DEF_OUTPUT_W,
    parameter int AddrWidth     = DEF_ADDR_W,
    parameter int TimeoutCycles = DEF_TIMEOUT
) (
    input  logic                   clkk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AddrWidth-1:0]   num_samples,
    output logic                   rd_en,
    output logic [AddrWidth-1:0]   rd_addr,
    input  logic [InputWidth-1:0]  rd_data,
    output logic                   fir_in_valid,
    output logic [InputWidth-1:0]  fir_in,
    input  logic                   fir_out_valid,
    input  logic [OutputWidth-1:0] fir_out,
    output logic                   wr_en,
    output logic [AddrWidth-1:0]   wr_addr,
    output logic [OutputWidth-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [AddrWidth-1:0]   sample_count
);

    fir_ctrl_state_t        r_state;
    fir_ctrl_state_t        w_stateNext;
    logic [AddrWidth-1:0]   r_numSamples;
    logic [AddrWidth-1:0]   r_idx;
    logic [AddrWidth-1:0]   r_rdAddr;
    logic [AddrWidth-1:0]   r_wrAddr;
    logic [AddrWidth-1:0]   r_sampleCount;
    logic [InputWidth-1:0]  r_firIn;
    logic [OutputWidth-1:0] r_wrData;
    logic                   r_timeoutErr;
    logic [AddrWidth-1:0]   w_idxInc;
    logic                   w_lastSample;
    logic                   w_timerExpired;

    assign w_idxInc     = r_idx + 1'b1;
    assign w_lastSample = (w_idxInc == r_numSamples);

    fir_timeout_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clkk    (clkk),
        .rst_n   (rst_n),
        .clear   (r_state == S_ISSUE),
        .enable  (r_state == S_WAIT),
        .expired (w_timerExpired)
    );

    always_ff @(posedge clkk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = (num_samples == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_stateNext = S_LOAD;
            S_LOAD:  w_stateNext = S_ISSUE;
            S_ISSUE: w_stateNext = S_WAIT;
            S_WAIT: begin
                if (fir_out_valid) begin
                    w_stateNext = S_STORE;
                end else if (w_timerExpired) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_STORE: w_stateNext = w_lastSample ? S_DONE : S_FETCH;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Addresses are loaded on entry to FETCH/STORE so they hold between strobes.
    always_ff @(posedge clkk) begin
        if (!rst_n) begin
            r_numSamples  <= '0;
            r_idx         <= '0;
            r_rdAddr      <= '0;
            r_wrAddr      <= '0;
            r_sampleCount <= '0;
            r_firIn       <= '0;
            r_wrData      <= '0;
            r_timeoutErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_numSamples  <= num_samples;
                        r_sampleCount <= '0;
                        r_timeoutErr  <= 1'b0;
                        r_idx         <= '0;
                        if (num_samples != '0) begin
                            r_rdAddr <= '0;
                        end
                    end
                end
                S_LOAD: r_firIn <= rd_data;
                S_WAIT: begin
                    if (fir_out_valid) begin
                        r_wrData <= fir_out;
                        r_wrAddr <= r_idx;
                    end else if (w_timerExpired) begin
                        r_timeoutErr <= 1'b1;
                    end
                end
                S_STORE: begin
                    r_sampleCount <= r_sampleCount + 1'b1;
                    if (!w_lastSample) begin
                        r_idx    <= w_idxInc;
                        r_rdAddr <= w_idxInc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_en        = (r_state == S_FETCH);
    assign rd_addr      = r_rdAddr;
    assign fir_in_valid = (r_state == S_ISSUE);
    assign fir_in       = r_firIn;
    assign wr_en        = (r_state == S_STORE);
    assign wr_addr      = r_wrAddr;
    assign wr_data      = r_wrData;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign timeout_err  = r_timeoutErr;
    assign sample_count = r_sampleCount;

endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
Sequencer that streams a block of samples from a sample RAM through the FIR core, one sample at a time. It waits for each FIR result and writes it to a result RAM. It sits between the sample/result memories and the FIR's inputValid/outputValid handshake, and replaces ad-hoc bench sequencing. It reports progress and completion, and raises a timeout error if the FIR stops responding.

Parameters:
InputWidth, 16, FIR sample width
OutputWidth, 38, FIR result width
AddrWidth, 18, sample/result memory address width; also the width of the sample counter
TimeoutCycles, 255, maximum WAIT cycles allowed before an error (range 1..255)

Ports:
clkk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a run; accepted only in IDLE
num_samples  in  AddrWidth  run length; latched when start is accepted
rd_en  out  1  sample RAM read strobe
rd_addr  out  AddrWidth  sample RAM address
rd_data  in  InputWidth  sample RAM data, valid the cycle after rd_en
fir_in_valid  out  1  FIR inputValid
fir_in  out  InputWidth  FIR sample input (registered)
fir_out_valid  in  1  FIR outputValid
fir_out  in  OutputWidth  FIR result
wr_en  out  1  result RAM write strobe
wr_addr  out  AddrWidth  result RAM address
wr_data  out  OutputWidth  result RAM data (registered)
busy  out  1  high from the cycle after start is accepted until the return to IDLE
done  out  1  one-cycle pulse at normal completion
timeout_err  out  1  sticky error flag; cleared when the next start is accepted
sample_count  out  AddrWidth  number of results written in the current run

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clkk. When rst_n=0 at a clkk edge:
  - state becomes IDLE;
  - every output and internal register becomes 0;
  - any in-flight sample is discarded, with no write.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, STORE, DONE. Run index idx counts 0..num_samples-1.
- IDLE:
  - On start=1: latch num_samples, clear sample_count, clear timeout_err, set idx=0.
  - Go to DONE if num_samples==0, else FETCH.
- FETCH: rd_en=1, rd_addr=idx → LOAD.
- LOAD: register rd_data into fir_in → ISSUE.
- ISSUE: fir_in_valid=1 for exactly this one cycle; clear the timer → WAIT.
- WAIT:
  - fir_out_valid is sampled only in this state. If it is high, register fir_out into wr_data → STORE.
  - Otherwise increment the timer. When the timer reaches TimeoutCycles, set timeout_err=1 → IDLE, with no write and no done.
- STORE:
  - wr_en=1, wr_addr=idx; increment sample_count.
  - If idx+1==latched count → DONE, else idx++ → FETCH.
- DONE: done=1 for one cycle → IDLE.
- Latency: a sample whose fir_out_valid arrives on the L-th WAIT cycle (L≥1) costs 4+L cycles from its FETCH to the next FETCH.
- Ignored inputs:
  - fir_out_valid is ignored in every state except WAIT.
  - start is ignored in every state except IDLE, including the DONE cycle.
  - num_samples changes are ignored after the latch.
- Addressing: addresses run 0..num_samples-1 with no wrap-around. The maximum run is 2^AddrWidth-1 samples.
- Outputs: all outputs are driven from registers or from state decode only; there are no combinational paths from inputs to outputs.
- rd_addr and wr_addr hold their last value when their strobe is low.

Decomposition:
- Package fir_ctrl_pkg holds:
  - the state enum (fir_ctrl_state_t, 3 bits);
  - the default widths;
  - TIMER_W = 8.
- One sub-module, fir_timeout_timer:
  - inputs clear and enable;
  - output expired, when count==TimeoutCycles;
  - synchronous active-low reset.
- The remaining control logic lives in fir_stream_ctrl.

Test Plan:
1. num_samples=4, RAM holds 1,2,3,4, FIR model latency L=3 returning 10×input → wr_en exactly 4 times, at addresses 0..3 with data 10,20,30,40. done pulse arrives 28 cycles after the first FETCH (+1 for DONE). sample_count=4, busy then low, timeout_err=0.
2. num_samples=0 → DONE the cycle after start, done pulse, no rd_en/fir_in_valid/wr_en, sample_count=0.
3. TimeoutCycles=8, FIR never asserts valid, num_samples=3 → after 8 WAIT cycles timeout_err=1, busy=0, no done, no wr_en, sample_count=0. A following start clears timeout_err.
4. start pulsed again in WAIT with num_samples=9 during a num=2 run → ignored: exactly 2 writes, one done.
5. rst_n=0 for one cycle during WAIT of sample 1 → next cycle all outputs 0, no wr_en. A new start with num=2 writes addresses 0,1.
6. fir_out_valid held high in IDLE and pulsed during ISSUE → no wr_en from those pulses. With L=1 valid in WAIT, each sample takes 5 cycles.
